// File: rtl/memory_access_pkg.sv
// Shared types for the memory stage: dbus transaction structs, pipeline bundles,
// the access-size encoding and the M-stage handshake states.
package memory_access_pkg;
  localparam int XLEN = 64;

  // ---- common: bus and op encoding ----
  typedef enum logic [3:0] {
    OP_ADD, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWU, OP_LD,
    OP_SB, OP_SH, OP_SW, OP_SD
  } op_t;

  typedef logic [2:0] msize_t;
  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
    msize_t          size;
    logic [7:0]      strobe;
    logic [XLEN-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic            addr_ok;
    logic            data_ok;
    logic [XLEN-1:0] data;
  } dbus_resp_t;

  // ---- pipes: stage bundles and M-stage FSM ----
  typedef struct packed {
    op_t  op;
    logic memread;
    logic memwrite;
    logic regwrite;
    logic nop_signal;
  } control_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] result_alu;
    logic [XLEN-1:0] wd;
    logic [4:0]      wa;
    control_t        ctl;
  } execute_data_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] result_alu;
    logic [4:0]      wa;
    control_t        ctl;
    logic            addr_31;
  } memory_data_t;

  typedef logic [1:0] mem_state_t;
  localparam mem_state_t IDLE = 2'd0;
  localparam mem_state_t WAIT = 2'd1;
  localparam mem_state_t DONE = 2'd2;

  function automatic msize_t opSize(input op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: opSize = MSIZE1;
      OP_LH, OP_LHU, OP_SH: opSize = MSIZE2;
      OP_LW, OP_LWU, OP_SW: opSize = MSIZE4;
      default:              opSize = MSIZE8;
    endcase
  endfunction
endpackage

// File: rtl/memory_access_mem_align.sv
// Byte-lane alignment for the memory stage: store strobe/data placement and
// load extraction with sign or zero extension.
module mem_align
  import memory_access_pkg::*;
(
  input  op_t             op,
  input  logic [2:0]      offset,
  input  logic [XLEN-1:0] wd,
  input  logic [XLEN-1:0] rdata,
  output msize_t          size,
  output logic [7:0]      strobe,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] loadValue
);
  logic [7:0]        byteMask;
  logic [5:0]        bitOff;
  logic [XLEN-1:0]   sh;
  logic signed [7:0]  shB;
  logic signed [15:0] shH;
  logic signed [31:0] shW;

  assign size   = opSize(op);
  assign bitOff = {offset, 3'b000};

  always_comb begin
    case (size)
      MSIZE1:  byteMask = 8'h01;
      MSIZE2:  byteMask = 8'h03;
      MSIZE4:  byteMask = 8'h0F;
      default: byteMask = 8'hFF;
    endcase
  end

  // Lanes above bit 7 / XLEN-1 fall off: misaligned requests go out as computed.
  assign strobe = byteMask << offset;
  assign wdata  = wd << bitOff;

  assign sh  = rdata >> bitOff;
  assign shB = sh[7:0];
  assign shH = sh[15:0];
  assign shW = sh[31:0];

  always_comb begin
    case (op)
      OP_LB:   loadValue = XLEN'(shB);
      OP_LH:   loadValue = XLEN'(shH);
      OP_LW:   loadValue = XLEN'(shW);
      OP_LBU:  loadValue = XLEN'(sh[7:0]);
      OP_LHU:  loadValue = XLEN'(sh[15:0]);
      OP_LWU:  loadValue = XLEN'(sh[31:0]);
      default: loadValue = sh;
    endcase
  end
endmodule

// File: rtl/memory_access.sv
// Memory stage: drives the dbus handshake for loads/stores, stalls upstream while
// the access is outstanding, and produces the M-stage bundle.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int MMIO_BIT = 31
) (
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  output dbus_req_t     dbus_req,
  input  dbus_resp_t    dbus_resp,
  output memory_data_t  dataM,
  output logic          stallM
);
  mem_state_t      state, stateNext;
  dbus_req_t       req_q, reqNew;
  logic [XLEN-1:0] rdata_q;
  logic            memOp, capture;
  msize_t          alignSize;
  logic [7:0]      alignStrobe;
  logic [XLEN-1:0] alignWdata, loadValue;
  logic            unusedAddrOk;

  // Address acceptance alone never advances the FSM.
  assign unusedAddrOk = dbus_resp.addr_ok;

  assign memOp = ~dataE.ctl.nop_signal & (dataE.ctl.memread | dataE.ctl.memwrite);

  mem_align u_align (
    .op       (dataE.ctl.op),
    .offset   (dataE.result_alu[2:0]),
    .wd       (dataE.wd),
    .rdata    (rdata_q),
    .size     (alignSize),
    .strobe   (alignStrobe),
    .wdata    (alignWdata),
    .loadValue(loadValue)
  );

  always_comb begin
    reqNew        = '0;
    reqNew.valid  = 1'b1;
    reqNew.addr   = dataE.result_alu;
    reqNew.size   = alignSize;
    reqNew.strobe = dataE.ctl.memwrite ? alignStrobe : 8'h00;
    reqNew.data   = alignWdata;
  end

  always_comb begin
    stateNext = state;
    capture   = 1'b0;
    dbus_req  = '0;
    stallM    = 1'b0;
    case (state)
      IDLE: if (memOp) begin
        dbus_req  = reqNew;
        stallM    = 1'b1;
        capture   = dbus_resp.data_ok;
        stateNext = dbus_resp.data_ok ? DONE : WAIT;
      end
      // Request replays from req_q so it stays stable until data_ok.
      WAIT: begin
        dbus_req = req_q;
        stallM   = 1'b1;
        if (dbus_resp.data_ok) begin
          capture   = 1'b1;
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (reset) begin
      dbus_req.valid = 1'b0;
      stallM         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rdata_q <= '0;
      req_q   <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && memOp) req_q <= reqNew;
      if (capture) rdata_q <= dbus_resp.data;
    end
  end

  // In DONE the frozen upstream still presents the same instruction.
  always_comb begin
    dataM            = '0;
    dataM.pc         = dataE.pc;
    dataM.wa         = dataE.wa;
    dataM.ctl        = dataE.ctl;
    dataM.result_alu = (state == DONE && memOp && dataE.ctl.memread) ? loadValue
                                                                     : dataE.result_alu;
    dataM.addr_31    = memOp & ~dataE.result_alu[MMIO_BIT];
    if (reset || stallM) dataM.ctl.nop_signal = 1'b1;
  end
endmodule

// File: tb/tb_memory_access.sv
// Directed bench for the memory stage: pass-through, store/load handshakes,
// alignment/extension, MMIO flag and reset during an outstanding access.
module tb_memory_access;
  import memory_access_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  execute_data_t dataE;
  dbus_req_t     dbusReq;
  dbus_resp_t    dbusResp;
  memory_data_t  dataM;
  logic          stallM;
  int            vectors = 0;
  int            miscompares = 0;

  memory_access #(.MMIO_BIT(31)) dut (
    .clk      (clk),
    .reset    (reset),
    .dataE    (dataE),
    .dbus_req (dbusReq),
    .dbus_resp(dbusResp),
    .dataM    (dataM),
    .stallM   (stallM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic execute_data_t mkE(input op_t op, input logic [63:0] pc,
                                        input logic [63:0] addr, input logic [63:0] wd,
                                        input logic rd, input logic wr);
    execute_data_t e;
    e              = '0;
    e.pc           = pc;
    e.result_alu   = addr;
    e.wd           = wd;
    e.wa           = 5'd7;
    e.ctl.op       = op;
    e.ctl.memread  = rd;
    e.ctl.memwrite = wr;
    e.ctl.regwrite = ~wr;
    return e;
  endfunction

  initial begin
    reset    = 1'b1;
    dbusResp = '0;
    dataE    = mkE(OP_LD, 64'h8000_0000, 64'h8000_0000, 64'h0, 1'b1, 1'b0);
    step();
    step();
    #2;
    chk("rst_valid", dbusReq.valid, 0);
    chk("rst_stall", stallM, 0);
    chk("rst_nop", dataM.ctl.nop_signal, 1);

    // Non-memory ADD passes straight through
    reset = 1'b0;
    dataE = mkE(OP_ADD, 64'h8000_0000, 64'h1234, 64'h99, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("add_stall", stallM, 0);
      chk("add_valid", dbusReq.valid, 0);
      chk("add_pc", dataM.pc, 64'h8000_0000);
      chk("add_res", dataM.result_alu, 64'h1234);
      chk("add_wa", dataM.wa, 7);
      chk("add_nop", dataM.ctl.nop_signal, 0);
      chk("add_a31", dataM.addr_31, 0);
      step();
    end

    // SB at offset 3, data_ok on the third valid cycle
    dataE = mkE(OP_SB, 64'h8000_0010, 64'h8000_0003, 64'hAB, 1'b0, 1'b1);
    dbusResp.addr_ok = 1'b1;
    #2;
    chk("sb0_valid", dbusReq.valid, 1);
    chk("sb0_stall", stallM, 1);
    chk("sb0_addr", dbusReq.addr, 64'h8000_0003);
    chk("sb0_size", dbusReq.size, MSIZE1);
    chk("sb0_strb", dbusReq.strobe, 8'h08);
    chk("sb0_data", dbusReq.data, 64'hAB00_0000);
    step();
    dbusResp.addr_ok = 1'b0;
    dataE.wd = 64'h55;
    #2;
    chk("sb1_valid", dbusReq.valid, 1);
    chk("sb1_stall", stallM, 1);
    chk("sb1_addr", dbusReq.addr, 64'h8000_0003);
    chk("sb1_strb", dbusReq.strobe, 8'h08);
    chk("sb1_data", dbusReq.data, 64'hAB00_0000);
    step();
    dataE.wd = 64'hAB;
    dbusResp.data_ok = 1'b1;
    #2;
    chk("sb2_valid", dbusReq.valid, 1);
    chk("sb2_stall", stallM, 1);
    chk("sb2_data", dbusReq.data, 64'hAB00_0000);
    step();
    dbusResp.data_ok = 1'b0;
    #2;
    chk("sb_done_valid", dbusReq.valid, 0);
    chk("sb_done_stall", stallM, 0);
    chk("sb_done_res", dataM.result_alu, 64'h8000_0003);
    chk("sb_done_nop", dataM.ctl.nop_signal, 0);
    chk("sb_done_a31", dataM.addr_31, 0);
    step();

    // SH at offset 2, immediate data_ok
    dataE = mkE(OP_SH, 64'h8000_0014, 64'h8000_0002, 64'hBEEF, 1'b0, 1'b1);
    dbusResp.data_ok = 1'b1;
    #2;
    chk("sh_size", dbusReq.size, MSIZE2);
    chk("sh_strb", dbusReq.strobe, 8'h0C);
    chk("sh_data", dbusReq.data, 64'hBEEF_0000);
    chk("sh_stall", stallM, 1);
    step();
    dbusResp.data_ok = 1'b0;
    #2;
    chk("sh_done_stall", stallM, 0);
    step();

    // LB / LBU of byte 5 = 0x80
    dataE = mkE(OP_LB, 64'h8000_0018, 64'h8000_0005, 64'h0, 1'b1, 1'b0);
    dbusResp.data_ok = 1'b1;
    dbusResp.data = 64'h0000_8000_0000_0000;
    #2;
    chk("lb_valid", dbusReq.valid, 1);
    chk("lb_size", dbusReq.size, MSIZE1);
    chk("lb_addr", dbusReq.addr, 64'h8000_0005);
    step();
    dbusResp.data_ok = 1'b0;
    dbusResp.data = 64'hDEAD_BEEF_DEAD_BEEF;
    #2;
    chk("lb_res", dataM.result_alu, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_stall", stallM, 0);
    step();
    dataE = mkE(OP_LBU, 64'h8000_001C, 64'h8000_0005, 64'h0, 1'b1, 1'b0);
    dbusResp.data_ok = 1'b1;
    dbusResp.data = 64'h0000_8000_0000_0000;
    step();
    dbusResp.data_ok = 1'b0;
    #2;
    chk("lbu_res", dataM.result_alu, 64'h80);
    step();

    // LW at offset 4 with data_ok in the first cycle
    dataE = mkE(OP_LW, 64'h8000_0020, 64'h8000_0004, 64'h0, 1'b1, 1'b0);
    dbusResp.data_ok = 1'b1;
    dbusResp.data = 64'h8765_4321_0000_0000;
    #2;
    chk("lw_stall0", stallM, 1);
    chk("lw_size", dbusReq.size, MSIZE4);
    step();
    dbusResp.data_ok = 1'b0;
    #2;
    chk("lw_stall1", stallM, 0);
    chk("lw_res", dataM.result_alu, 64'hFFFF_FFFF_8765_4321);
    step();

    // LD in device space, then in memory space
    dataE = mkE(OP_LD, 64'h8000_0024, 64'h4000_0000, 64'h0, 1'b1, 1'b0);
    dbusResp.data_ok = 1'b1;
    dbusResp.data = 64'h1122_3344_5566_7788;
    #2;
    chk("ld_size", dbusReq.size, MSIZE8);
    step();
    dbusResp.data_ok = 1'b0;
    #2;
    chk("ld_a31", dataM.addr_31, 1);
    chk("ld_res", dataM.result_alu, 64'h1122_3344_5566_7788);
    step();
    dataE = mkE(OP_LD, 64'h8000_0028, 64'h8000_0000, 64'h0, 1'b1, 1'b0);
    dbusResp.data_ok = 1'b1;
    step();
    dbusResp.data_ok = 1'b0;
    #2;
    chk("ld2_a31", dataM.addr_31, 0);
    step();

    // Reset while waiting for data_ok; late data_ok must be ignored
    dataE = mkE(OP_LW, 64'h8000_002C, 64'h8000_0008, 64'h0, 1'b1, 1'b0);
    #2;
    chk("rw_valid0", dbusReq.valid, 1);
    step();
    #2;
    chk("rw_valid1", dbusReq.valid, 1);
    chk("rw_stall1", stallM, 1);
    reset = 1'b1;
    dataE = mkE(OP_ADD, 64'h8000_0030, 64'h77, 64'h0, 1'b0, 1'b0);
    #2;
    chk("rw_valid_rst", dbusReq.valid, 0);
    chk("rw_stall_rst", stallM, 0);
    step();
    reset = 1'b0;
    #2;
    chk("rw_valid_after", dbusReq.valid, 0);
    chk("rw_stall_after", stallM, 0);
    chk("rw_nop_after", dataM.ctl.nop_signal, 0);
    dbusResp.data_ok = 1'b1;
    dbusResp.data = 64'hFFFF_FFFF_FFFF_FFFF;
    #2;
    chk("late_res", dataM.result_alu, 64'h77);
    chk("late_stall", stallM, 0);
    chk("late_valid", dbusReq.valid, 0);
    step();
    dbusResp.data_ok = 1'b0;
    #2;
    chk("late_res2", dataM.result_alu, 64'h77);
    chk("late_stall2", stallM, 0);
    step();

    // Fresh access after reset completes normally
    dataE = mkE(OP_LBU, 64'h8000_0034, 64'h8000_0001, 64'h0, 1'b1, 1'b0);
    dbusResp.data_ok = 1'b1;
    dbusResp.data = 64'h0000_0000_0000_CC00;
    #2;
    chk("post_stall", stallM, 1);
    step();
    dbusResp.data_ok = 1'b0;
    #2;
    chk("post_res", dataM.result_alu, 64'hCC);
    chk("post_stall_done", stallM, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
